// File: rtl/hazard_scoreboard.sv
// Issue-stage interlock: per-register countdown/div-pending scoreboard raising RAW/WAW stalls,
// merged with cache/div/priv stalls and a sticky exception-drain stall. Outputs are combinational.
module hazard_scoreboard #(
  parameter int ISSUE_W  = 2,
  parameter int NREG     = 32,
  parameter int MUL_LAT  = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = $clog2(((MUL_LAT > LOAD_LAT) ? MUL_LAT : LOAD_LAT) + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISSUE_W-1:0]   iss_valid,
  input  logic [5*ISSUE_W-1:0] iss_rj,
  input  logic [5*ISSUE_W-1:0] iss_rk,
  input  logic [5*ISSUE_W-1:0] iss_rd,
  input  logic [ISSUE_W-1:0]   iss_we,
  input  logic [2*ISSUE_W-1:0] iss_cls,
  input  logic [ISSUE_W-1:0]   iss_exc,
  input  logic                 div_done,
  input  logic [4:0]           div_done_rd,
  input  logic                 flush,
  input  logic                 stall_because_cache,
  input  logic                 stall_because_div,
  input  logic                 stall_because_priv,
  output logic                 stall,
  output logic                 stall_raw,
  output logic                 stall_exc,
  output logic                 issue_fire
);

  typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_MUL = 2'd1, CLS_LOAD = 2'd2, CLS_DIV = 2'd3} cls_e;

  localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);

  logic [CNT_W-1:0] cnt    [NREG];
  logic [CNT_W-1:0] wr_cnt [NREG];
  logic [NREG-1:0]  div_pend;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  wr_hit;
  logic [NREG-1:0]  wr_div;
  logic             exc_hold;
  logic             exc_now;
  logic             hazard;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt[r] != '0) | div_pend[r];
    end
  end

  // r0 is never busy, so source reads of r0 fall out of the busy lookup naturally.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < ISSUE_W; s++) begin
      if (iss_valid[s]) begin
        if (busy[iss_rj[5*s +: 5]] || busy[iss_rk[5*s +: 5]]) hazard = 1'b1;
        if (iss_we[s] && iss_rd[5*s +: 5] != 5'd0) begin
          if (div_pend[iss_rd[5*s +: 5]]) hazard = 1'b1;
          case (cls_e'(iss_cls[2*s +: 2]))
            CLS_ALU:  if (cnt[iss_rd[5*s +: 5]] != '0)       hazard = 1'b1;
            CLS_MUL:  if (cnt[iss_rd[5*s +: 5]] > MUL_INIT)  hazard = 1'b1;
            CLS_LOAD: if (cnt[iss_rd[5*s +: 5]] > LOAD_INIT) hazard = 1'b1;
            default:  ;
          endcase
        end
      end
    end
  end

  assign exc_now    = |(iss_valid & iss_exc);
  assign stall_raw  = hazard & ~stall_because_cache;
  assign stall_exc  = exc_hold | exc_now;
  assign stall      = stall_because_cache | stall_because_div | stall_because_priv |
                      stall_raw | stall_exc;
  assign issue_fire = (|iss_valid) & ~stall;

  // Slots are walked oldest first so the youngest writer of a shared rd wins.
  always_comb begin
    wr_hit = '0;
    wr_div = '0;
    for (int r = 0; r < NREG; r++) wr_cnt[r] = '0;
    if (issue_fire) begin
      for (int s = 0; s < ISSUE_W; s++) begin
        if (iss_valid[s] && iss_we[s] && iss_rd[5*s +: 5] != 5'd0) begin
          wr_hit[iss_rd[5*s +: 5]] = 1'b1;
          case (cls_e'(iss_cls[2*s +: 2]))
            CLS_MUL:  begin wr_cnt[iss_rd[5*s +: 5]] = MUL_INIT;  wr_div[iss_rd[5*s +: 5]] = 1'b0; end
            CLS_LOAD: begin wr_cnt[iss_rd[5*s +: 5]] = LOAD_INIT; wr_div[iss_rd[5*s +: 5]] = 1'b0; end
            CLS_DIV:  begin wr_cnt[iss_rd[5*s +: 5]] = '0;        wr_div[iss_rd[5*s +: 5]] = 1'b1; end
            default:  begin wr_cnt[iss_rd[5*s +: 5]] = '0;        wr_div[iss_rd[5*s +: 5]] = 1'b0; end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      div_pend <= '0;
      exc_hold <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_hit[r])
          cnt[r] <= wr_cnt[r];
        else if (!stall_because_cache && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
        // A same-cycle divide issue to the finishing register keeps it pending.
        if (wr_hit[r])
          div_pend[r] <= wr_div[r];
        else if (div_done && div_done_rd == 5'(r))
          div_pend[r] <= 1'b0;
      end
      exc_hold <= exc_hold | exc_now;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised issue-stage interlock unit for the CLAP execute pipeline, sitting between register-read and exe0. It tracks in-flight long-latency writers (multiply, load, divide) in a per-register countdown scoreboard and raises RAW/WAW stalls for up to ISSUE_W slots. It merges external cache, divide and privileged stalls with a sticky exception-drain stall into one prioritised stall vector.

## Interface
- ISSUE_W, 2, issue slots per cycle; slot 0 is oldest
- NREG, 32, architectural registers; r0 never tracked
- MUL_LAT, 2, cycles from mul issue until a consumer may issue (≥1)
- LOAD_LAT, 2, same for loads (≥1)
- CNT_W, $clog2(max(MUL_LAT,LOAD_LAT)+1), countdown width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iss_valid  in  ISSUE_W  slot holds an instruction
- iss_rj, iss_rk, iss_rd  in  5*ISSUE_W  source/destination per slot
- iss_we  in  ISSUE_W  slot writes rd
- iss_cls  in  2*ISSUE_W  0=alu, 1=mul, 2=load, 3=div
- iss_exc  in  ISSUE_W  slot carries an exception code
- div_done  in  1  divider wrote back this cycle
- div_done_rd  in  5  destination of finishing divide
- flush  in  1  pipeline flush (exception/branch redirect)
- stall_because_cache, stall_because_div, stall_because_priv  in  1 each
- stall  out  1  freeze issue stage
- stall_raw  out  1  scoreboard RAW/WAW interlock (bubble inserted)
- stall_exc  out  1  exception drain in progress
- issue_fire  out  1  bundle accepted this cycle

## Operation
- State: cnt[r] (CNT_W bits) and div_pend[r] (1 bit) for r in 1..NREG-1; exc_hold (1 bit).
- Register r busy when cnt[r]!=0 or div_pend[r].
- RAW: any valid slot whose rj or rk equals a busy nonzero register.
- WAW: valid slot with iss_we, rd!=0, and either div_pend[rd] or cnt[rd] > (slot latency−1).
- Intra-bundle dependencies are resolved by the issue stage; not checked here.
- stall_raw = (RAW|WAW) & !stall_because_cache (cache stall takes priority).
- stall_exc = exc_hold | (|(iss_valid & iss_exc)).
- stall = stall_because_cache | stall_because_div | stall_because_priv | stall_raw | stall_exc.
- issue_fire = (|iss_valid) & !stall.
- On issue_fire, each slot with iss_we, rd!=0: mul → cnt[rd]=MUL_LAT−1; load → cnt[rd]=LOAD_LAT−1; div → div_pend[rd]=1, cnt[rd]=0; alu → cnt[rd]=0, div_pend[rd]=0. Same rd in several slots: highest slot index wins.
- Countdown: every cycle with !stall_because_cache, each nonzero cnt not being written decrements by 1; saturates at 0. During cache stall all counters hold.
- div_done clears div_pend[div_done_rd]; same-cycle div issue to same rd: set wins.
- exc_hold sets when any valid slot has iss_exc and is not already flushed; clears only on flush.
- flush: all cnt, div_pend and exc_hold cleared next cycle; flush overrides same-cycle set and issue.

## Timing
- Reset: all counters, div_pend, exc_hold = 0; outputs purely combinational from state and inputs, so with iss_valid=0 after reset stall=0, stall_raw=0, stall_exc=0, issue_fire=0.
- Producer issued in cycle t with latency L: dependent consumer first issues in cycle t+L (L−1 bubbles) absent cache stall; each cache-stall cycle adds one.
- div consumer issues the cycle after div_done.
- stall_exc asserts same cycle the exception arrives, stays high until the cycle after flush.
- Reset mid-operation: state cleared next edge regardless of other inputs.

## Test plan
- Reset then mul r5 in slot 0, next cycle add r6,r5,r1 in slot 1 → stall_raw=1 for 1 cycle, consumer fires 2 cycles after mul (MUL_LAT=2).
- Load r7, consumer next cycle with stall_because_cache=1 for 3 cycles → stall_raw=0 during cache stall, cnt[7] holds at 1, stall_raw=1 one cycle after cache releases, then fire.
- Div r9 issued, consumer of r9 waits 12 cycles → stall_raw held until div_done with div_done_rd=9, consumer fires next cycle; div_done_rd=10 has no effect.
- Writer to r0 (mul r0) then reader of r0 → no stall.
- Slot 0 exception code nonzero → stall_exc=1 and stall=1 same cycle, held until flush; after flush scoreboard empty, pending load to r3 no longer stalls.
- Mul r4 and alu r4 in slots 0/1 same bundle, reader of r4 next cycle → no stall (slot 1 wins); load r4 then alu r4 next cycle with LOAD_LAT=3 → WAW stall until cnt[4]=0.
